// File: rtl/alu_pkg.sv
// Shared types and constants for the multicycle execute-stage ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_NOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SLTU  = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_MULT  = 4'b1010,
    ALU_MULTU = 4'b1011,
    ALU_DIV   = 4'b1100,
    ALU_DIVU  = 4'b1101,
    ALU_SLT   = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

  // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
  localparam int MAX_WIDTH = 128;
  localparam logic [MAX_WIDTH-1:0] DIV0_LO = {MAX_WIDTH{1'b1}};

  function automatic logic is_muldiv(input alu_op_t op);
    case (op)
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: is_muldiv = 1'b1;
      default:                                 is_muldiv = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_alu_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide on
// magnitudes, sign fix-up in a final cycle, HI/LO result registers.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  alu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               is_div_q, is_div_d;
  logic               sgn_q, sgn_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               div0_q, div0_d;

  logic               op_div_s, op_sgn_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH-1:0]   mul_add_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_sub_s;
  logic               res_neg_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;

  assign op_div_s = (op_i == ALU_DIV) || (op_i == ALU_DIVU);
  assign op_sgn_s = (op_i == ALU_MULT) || (op_i == ALU_DIV);
  assign a_neg_s  = op_sgn_s & a_i[WIDTH-1];
  assign b_neg_s  = op_sgn_s & b_i[WIDTH-1];
  assign a_mag_s  = a_neg_s ? ({WIDTH{1'b0}} - a_i) : a_i;
  assign b_mag_s  = b_neg_s ? ({WIDTH{1'b0}} - b_i) : b_i;

  // Multiply: rem_q holds the running upper half, low_q the shifting multiplier.
  assign mul_add_s = low_q[0] ? mag_b_q : {WIDTH{1'b0}};
  assign mul_sum_s = {1'b0, rem_q} + {1'b0, mul_add_s};

  // Divide: the partial remainder stays below the divisor, so WIDTH bits suffice.
  assign div_shift_s = {rem_q, low_q[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, mag_b_q});
  assign div_sub_s   = div_shift_s[WIDTH-1:0] - mag_b_q;

  assign res_neg_s  = sgn_q & (neg_a_q ^ neg_b_q);
  assign prod_s     = {rem_q, low_q};
  assign prod_fix_s = res_neg_s ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
  assign quot_fix_s = res_neg_s ? ({WIDTH{1'b0}} - low_q) : low_q;
  assign rem_fix_s  = (sgn_q & neg_a_q) ? ({WIDTH{1'b0}} - rem_q) : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rem_d    = rem_q;
    low_d    = low_q;
    mag_b_d  = mag_b_q;
    is_div_d = is_div_q;
    sgn_d    = sgn_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    case (state_q)
      IDLE: begin
        if (start_i && is_muldiv(op_i)) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
          rem_d    = {WIDTH{1'b0}};
          low_d    = a_mag_s;
          mag_b_d  = b_mag_s;
          is_div_d = op_div_s;
          sgn_d    = op_sgn_s;
          neg_a_d  = a_neg_s;
          neg_b_d  = b_neg_s;
          div0_d   = (b_i == {WIDTH{1'b0}});
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (is_div_q) begin
          rem_d = div_ge_s ? div_sub_s : div_shift_s[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], div_ge_s};
        end else begin
          rem_d = mul_sum_s[WIDTH:1];
          low_d = {mul_sum_s[0], low_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_STEP) begin
          state_d = FIX;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix_s;
          lo_d = div0_q ? DIV0_LO[WIDTH-1:0] : quot_fix_s;
        end else begin
          hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
          lo_d = prod_fix_s[WIDTH-1:0];
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset aborts any operation in flight without touching HI/LO beyond clearing them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      low_q    <= {WIDTH{1'b0}};
      mag_b_q  <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rem_q    <= rem_d;
      low_q    <= low_d;
      mag_b_q  <= mag_b_d;
      is_div_q <= is_div_d;
      sgn_q    <= sgn_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: combinational logic/arith/shift ops plus an optional
// iterative mul/div unit built only when ALU_MULDIV_EN is defined.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ALU_operation,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic             start,
  output logic [WIDTH-1:0] ALU_output,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_op_t          op_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH-1:0] result_s;

  assign op_s    = alu_op_t'(ALU_operation);
  assign shamt_s = input_1[SHAMT_W-1:0];

  // Mul/div encodings and 1110 fall through to zero.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (op_s)
      ALU_AND:  result_s = input_1 & input_2;
      ALU_OR:   result_s = input_1 | input_2;
      ALU_ADD:  result_s = input_1 + input_2;
      ALU_XOR:  result_s = input_1 ^ input_2;
      ALU_NOR:  result_s = ~(input_1 | input_2);
      ALU_SLL:  result_s = input_2 << shamt_s;
      ALU_SUB:  result_s = input_1 - input_2;
      ALU_SLTU: result_s = {{(WIDTH-1){1'b0}}, (input_1 < input_2)};
      ALU_SRL:  result_s = input_2 >> shamt_s;
      ALU_SRA:  result_s = $signed(input_2) >>> shamt_s;
      ALU_SLT:  result_s = {{(WIDTH-1){1'b0}}, ($signed(input_1) < $signed(input_2))};
      default:  result_s = {WIDTH{1'b0}};
    endcase
  end

  assign ALU_output = result_s;
  assign zero       = (result_s == {WIDTH{1'b0}});

`ifdef ALU_MULDIV_EN
  muldiv_unit #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk_i   (clk),
    .reset_i (reset),
    .op_i    (op_s),
    .a_i     (input_1),
    .b_i     (input_2),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );
`else
  logic unused_muldiv_s;
  assign unused_muldiv_s = ^{clk, reset, start};
  assign busy = 1'b0;
  assign done = 1'b0;
  assign hi   = {WIDTH{1'b0}};
  assign lo   = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=32); mul/div cases run when ALU_MULDIV_EN is defined.
module tb_multicycle_alu;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  ALU_operation;
  logic [31:0] input_1;
  logic [31:0] input_2;
  logic        start;
  logic [31:0] ALU_output;
  logic        zero;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  string       cmb_name_q[$];
  logic [31:0] cmb_exp_q[$];
  string       md_name_q[$];
  logic [31:0] md_hi_q[$];
  logic [31:0] md_lo_q[$];

  multicycle_alu #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .ALU_operation (ALU_operation),
    .input_1       (input_1),
    .input_2       (input_2),
    .start         (start),
    .ALU_output    (ALU_output),
    .zero          (zero),
    .busy          (busy),
    .done          (done),
    .hi            (hi),
    .lo            (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
    ALU_operation = op;
    input_1       = a;
    input_2       = b;
    start         = st;
  endtask

  task automatic comb(input string name, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    @(posedge clk); #1;
    drive(op, a, b, 1'b0);
    cmb_name_q.push_back(name);
    cmb_exp_q.push_back(exp);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle where done is high.
  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit mid_start);
    int cycles;
    drive(op, a, b, 1'b1);
    md_name_q.push_back(name);
    md_hi_q.push_back(ehi);
    md_lo_q.push_back(elo);
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (mid_start && cycles == 5) drive(ALU_DIVU, 32'd9, 32'd3, 1'b1);
      else start = 1'b0;
      @(posedge clk); #1;
    end
    check({name, "_busy_len"}, 32'(cycles), 32'd33);
  endtask

  // Monitor: pops expected values whenever the DUT presents a result.
  always @(negedge clk) begin
    if (cmb_name_q.size() > 0) begin
      string       nm;
      logic [31:0] ex;
      nm = cmb_name_q.pop_front();
      ex = cmb_exp_q.pop_front();
      check(nm, ALU_output, ex);
      check({nm, "_zero"}, {31'b0, zero}, {31'b0, (ex == 32'd0)});
    end
    if (done === 1'b1) begin
      if (md_name_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got hi=0x%08h lo=0x%08h expected no done", hi, lo);
      end else begin
        string       nm;
        logic [31:0] eh;
        logic [31:0] el;
        nm = md_name_q.pop_front();
        eh = md_hi_q.pop_front();
        el = md_lo_q.pop_front();
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(ALU_AND, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;

    comb("sub_5_7",   ALU_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE);
    comb("sltu",      ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
    comb("slt",       ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
    comb("sra4",      ALU_SRA,  32'd4,         32'h8000_0000, 32'hF800_0000);
    comb("add_zero",  ALU_ADD,  32'd0,         32'd0,         32'd0);
    comb("add_wrap",  ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0);
    comb("and",       ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    comb("or",        ALU_OR,   32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF);
    comb("xor",       ALU_XOR,  32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0);
    comb("nor",       ALU_NOR,  32'd0,         32'd0,         32'hFFFF_FFFF);
    comb("sll_shamt", ALU_SLL,  32'd36,        32'd1,         32'h0000_0010);
    comb("srl8",      ALU_SRL,  32'd8,         32'h8000_0000, 32'h0080_0000);
    comb("illegal",   4'b1110,  32'd5,         32'd7,         32'd0);
    comb("mult_out",  ALU_MULT, 32'd5,         32'd7,         32'd0);

`ifdef ALU_MULDIV_EN
    @(posedge clk); #1;
    run_md("mult_neg",  ALU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_md("multu_max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_md("div_neg",   ALU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md("divu_0",    ALU_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b0);
    run_md("div_ovf",   ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run_md("mid_start", ALU_MULT,  32'd6,         32'd7,         32'd0,         32'd42,        1'b1);
    repeat (40) @(posedge clk);
    #1;

    // Reset at cycle 10 of a divide: no result, HI/LO cleared.
    drive(ALU_DIV, 32'd1000, 32'd7, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    run_md("mult_after", ALU_MULT, 32'h0001_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFE_0000, 1'b0);

    // Reset and start on the same edge: the start is dropped.
    @(posedge clk); #1;
    drive(ALU_MULTU, 32'd5, 32'd5, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
`else
    @(posedge clk); #1;
    drive(ALU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i % 10 == 0) begin
        check("dis_busy", {31'b0, busy}, 32'd0);
        check("dis_out", ALU_output, 32'd0);
        check("dis_hi", hi, 32'd0);
        check("dis_lo", lo, 32'd0);
      end
    end
    start = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_pending", 32'(md_name_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised next-generation execute-stage ALU for the MIPS core. Single-cycle logic, arithmetic, compare and shift operations are combinational. Iterative multiply/divide (MULT/MULTU/DIV/DIVU) runs in a sequential unit that writes HI/LO registers and stalls the pipeline through `busy`.

## Interface
- `WIDTH`, 32: datapath width in bits; must be ≥ 8 and even.
- `SHAMT_W`, $clog2(WIDTH): shift-amount bits taken from `input_1[SHAMT_W-1:0]`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `ALU_operation` input 4: operation select, `alu_op_t`.
- `input_1` input WIDTH: operand A (shift amount for shifts).
- `input_2` input WIDTH: operand B (value shifted for shifts).
- `start` input 1: request a mul/div; sampled only when the op is MULT/MULTU/DIV/DIVU.
- `ALU_output` output WIDTH: combinational result.
- `zero` output 1: `ALU_output == 0`.
- `busy` output 1: mul/div in progress; the pipeline stalls while it is high.
- `done` output 1: one-cycle pulse when HI/LO are updated.
- `hi`, `lo` output WIDTH each: HI/LO registers.

## Operation
- Combinational op encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR.
  - 0101 SLL, 0110 SUB, 0111 SLTU (unsigned), 1000 SRL, 1001 SRA, 1111 SLT (signed).
- Mul/div op encodings: 1010 MULT, 1011 MULTU, 1100 DIV, 1101 DIVU.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow output.
  - SLT/SLTU return 1 or 0, zero-extended.
  - Shifts use only the low SHAMT_W bits of `input_1`.
- `ALU_output` is 0 for mul/div ops and for 1110 (illegal); `zero` follows `ALU_output`.
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on `start` with a mul/div op. Operands are latched as magnitudes and the signs are recorded.
  - RUN: one shift-add or restoring-subtract step per cycle, WIDTH steps, counted by a `$clog2(WIDTH+1)`-bit counter.
  - RUN→FIX after the last step.
  - FIX→IDLE: sign correction, HI/LO write, `done`=1.
- Results:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH product.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero: hi = dividend, lo = all ones. No exception.
- Signed DIV of most-negative by −1: lo = most-negative, hi = 0.
- `start` is ignored while `busy`; there is no queueing.
- Combinational ops remain valid while `busy`.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, FSM=IDLE, counter=0. `ALU_output` and `zero` are combinational only.
- Start accepted at edge E0. busy is high after E0 through edge E(WIDTH+1), i.e. WIDTH+1 cycles.
- HI/LO are written and done=1 after edge E(WIDTH+1); done drops at the next edge.
- Latency from start to result is WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back: a new start is accepted in the cycle where done=1.
- `reset` asserted mid-operation aborts the operation. On that edge: busy=0, done=0, hi/lo=0, and no partial write occurs.
- `reset` and `start` on the same edge: reset wins and the start is dropped.

## Configuration
- Macro: `ALU_MULDIV_EN`.
- Defined: full behaviour as above.
- Undefined:
  - No FSM or HI/LO registers are built.
  - busy=0, done=0, hi=0, lo=0 constant.
  - Mul/div encodings behave as illegal (ALU_OUTPUT=0).
  - `start` is ignored.

## Structure
- Package `alu_pkg`:
  - `alu_op_t` enum with the encodings above.
  - `muldiv_state_t` enum {IDLE, RUN, FIX}.
  - `DIV0_LO` constant (all ones).
- Sub-module `muldiv_unit`: FSM, counter, iterative datapath, HI/LO registers; parametrised by WIDTH.
- The top level holds the combinational ALU and the `ALU_MULDIV_EN` generate guard around `muldiv_unit`.

## Test plan
All cases use WIDTH=32.
- Combinational sweep: SUB 5−7 → 0xFFFFFFFE; SLTU(0xFFFFFFFF,1) → 0; SLT → 1; SRA shamt=4 of 0x80000000 → 0xF8000000; zero=1 for ADD 0+0.
- MULT −3×7 → busy for 33 cycles; then done pulse with hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF² → hi=0xFFFFFFFE, lo=1.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/0 → hi=100, lo=0xFFFFFFFF. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- Start pulsed mid-RUN is ignored: exactly one done, with the original result.
- Reset asserted at cycle 10 of a DIV → next cycle busy=0, hi=lo=0, no done. A fresh MULT afterwards completes correctly.
- Build without `ALU_MULDIV_EN`: start with MULT → busy and done stay 0, ALU_output=0, hi=lo=0.
